ccl_table_ctrl: RTL and testbench

Sequencer for the connected-component label equivalence table. It owns the single port of an external equivalence RAM and steps it through four frame phases: clear, union during the first-pass scan, flatten, and root resolve for the second-pass relabeler. It sits between the first-pass labeler (union source), the second-pass relabeler (find source) and the table RAM. The RAM never sees two masters.

---
 rtl/ccl_table_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_ccl_table_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccl_table_ctrl.sv
// Equivalence-table sequencer for connected-component labelling: owns the single
// table RAM port across the clear, union, flatten and root-resolve phases of a frame.
module ccl_table_ctrl #(
    parameter int LABEL_WIDTH = 16,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   union_valid,
    output logic                   union_ready,
    input  logic [LABEL_WIDTH-1:0] union_a,
    input  logic [LABEL_WIDTH-1:0] union_b,
    input  logic                   scan_done,
    input  logic [LABEL_WIDTH-1:0] max_label,
    input  logic                   find_valid,
    output logic                   find_ready,
    input  logic [LABEL_WIDTH-1:0] find_label,
    output logic                   root_valid,
    output logic [LABEL_WIDTH-1:0] root_label,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_we,
    output logic [LABEL_WIDTH-1:0] ram_wdata,
    input  logic [LABEL_WIDTH-1:0] ram_rdata,
    output logic [2:0]             phase,
    output logic                   err
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CLEAR   = 4'd1;
    localparam logic [3:0] S_SCAN    = 4'd2;
    localparam logic [3:0] S_WA_ISS  = 4'd3;
    localparam logic [3:0] S_WA_CHK  = 4'd4;
    localparam logic [3:0] S_WB_ISS  = 4'd5;
    localparam logic [3:0] S_WB_CHK  = 4'd6;
    localparam logic [3:0] S_LINK    = 4'd7;
    localparam logic [3:0] S_FL_ISS  = 4'd8;
    localparam logic [3:0] S_FL_CHK  = 4'd9;
    localparam logic [3:0] S_FL_ISS2 = 4'd10;
    localparam logic [3:0] S_FL_CHK2 = 4'd11;
    localparam logic [3:0] S_FL_WR   = 4'd12;
    localparam logic [3:0] S_RESOLVE = 4'd13;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LABEL_WIDTH-1:0] LABEL_ZERO = {LABEL_WIDTH{1'b0}};

    logic [3:0]            state_r;
    logic [ADDR_WIDTH-1:0] x_r, b_r, ra_r, idx_r, maxl_r;
    logic                  pending_r;
    logic                  v1_r, v2_r, oor1_r, oor2_r;

    logic                  a_oor_s, b_oor_s, f_oor_s;
    logic                  union_fire_s, union_nop_s;
    logic                  rd_is_x_s, rd_is_idx_s, flat_last_s;
    logic [ADDR_WIDTH-1:0] maxl_clamp_s, rd_addr_s;

    function automatic logic out_of_range(input logic [LABEL_WIDTH-1:0] lbl);
        return |(lbl >> ADDR_WIDTH);
    endfunction

    // Request classification and read-data comparisons
    always_comb begin
        a_oor_s      = out_of_range(union_a);
        b_oor_s      = out_of_range(union_b);
        f_oor_s      = out_of_range(find_label);
        union_fire_s = union_valid && union_ready;
        union_nop_s  = a_oor_s || b_oor_s || (union_a == LABEL_ZERO) ||
                       (union_b == LABEL_ZERO) || (union_a == union_b);
        if (out_of_range(max_label)) begin
            maxl_clamp_s = ADDR_LAST;
        end else begin
            maxl_clamp_s = ADDR_WIDTH'(max_label);
        end
        rd_addr_s   = ADDR_WIDTH'(ram_rdata);
        rd_is_x_s   = (ram_rdata == LABEL_WIDTH'(x_r));
        rd_is_idx_s = (ram_rdata == LABEL_WIDTH'(idx_r));
        flat_last_s = (idx_r == maxl_r);
    end

    // Phase sequencer, RAM port and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            phase       <= 3'd0;
            union_ready <= 1'b0;
            find_ready  <= 1'b0;
            root_valid  <= 1'b0;
            root_label  <= LABEL_ZERO;
            ram_addr    <= ADDR_ZERO;
            ram_we      <= 1'b0;
            ram_wdata   <= LABEL_ZERO;
            err         <= 1'b0;
            x_r         <= ADDR_ZERO;
            b_r         <= ADDR_ZERO;
            ra_r        <= ADDR_ZERO;
            idx_r       <= ADDR_ZERO;
            maxl_r      <= ADDR_ZERO;
            pending_r   <= 1'b0;
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            oor1_r      <= 1'b0;
            oor2_r      <= 1'b0;
        end else if (frame_start) begin
            state_r     <= S_CLEAR;
            phase       <= 3'd1;
            union_ready <= 1'b0;
            find_ready  <= 1'b0;
            root_valid  <= 1'b0;
            ram_addr    <= ADDR_ZERO;
            ram_we      <= 1'b1;
            ram_wdata   <= LABEL_ZERO;
            err         <= 1'b0;
            pending_r   <= 1'b0;
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
        end else begin
            root_valid <= 1'b0;
            // A scan_done seen while a union is in flight waits for LINK to finish
            if (scan_done && (phase == 3'd2)) begin
                pending_r <= 1'b1;
                maxl_r    <= maxl_clamp_s;
            end
            case (state_r)
                S_IDLE: begin
                    state_r <= S_IDLE;
                end
                S_CLEAR: begin
                    if (ram_addr == ADDR_LAST) begin
                        state_r     <= S_SCAN;
                        phase       <= 3'd2;
                        ram_we      <= 1'b0;
                        union_ready <= 1'b1;
                    end else begin
                        ram_addr  <= ram_addr + ADDR_ONE;
                        ram_wdata <= LABEL_WIDTH'(ram_addr + ADDR_ONE);
                    end
                end
                S_SCAN: begin
                    if (pending_r) begin
                        union_ready <= 1'b0;
                        pending_r   <= 1'b0;
                        if (maxl_r == ADDR_ZERO) begin
                            state_r    <= S_RESOLVE;
                            phase      <= 3'd4;
                            find_ready <= 1'b1;
                        end else begin
                            state_r  <= S_FL_ISS;
                            phase    <= 3'd3;
                            idx_r    <= ADDR_ONE;
                            ram_addr <= ADDR_ONE;
                        end
                    end else if (union_fire_s) begin
                        union_ready <= 1'b0;
                        err         <= err | a_oor_s | b_oor_s;
                        if (!union_nop_s) begin
                            x_r      <= ADDR_WIDTH'(union_a);
                            b_r      <= ADDR_WIDTH'(union_b);
                            ram_addr <= ADDR_WIDTH'(union_a);
                            state_r  <= S_WA_ISS;
                        end
                    end else if (scan_done) begin
                        union_ready <= 1'b0;
                    end else begin
                        union_ready <= 1'b1;
                    end
                end
                S_WA_ISS: state_r <= S_WA_CHK;
                S_WA_CHK: begin
                    if (rd_is_x_s) begin
                        ra_r     <= x_r;
                        x_r      <= b_r;
                        ram_addr <= b_r;
                        state_r  <= S_WB_ISS;
                    end else begin
                        x_r      <= rd_addr_s;
                        ram_addr <= rd_addr_s;
                        state_r  <= S_WA_ISS;
                    end
                end
                S_WB_ISS: state_r <= S_WB_CHK;
                S_WB_CHK: begin
                    if (rd_is_x_s) begin
                        state_r <= S_LINK;
                        // Larger root points at the smaller one, keeping table[i] <= i
                        if (ra_r != x_r) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= (ra_r > x_r) ? ra_r : x_r;
                            ram_wdata <= LABEL_WIDTH'((ra_r > x_r) ? x_r : ra_r);
                        end
                    end else begin
                        x_r      <= rd_addr_s;
                        ram_addr <= rd_addr_s;
                        state_r  <= S_WB_ISS;
                    end
                end
                S_LINK: begin
                    ram_we      <= 1'b0;
                    state_r     <= S_SCAN;
                    union_ready <= !(pending_r || scan_done);
                end
                S_FL_ISS: state_r <= S_FL_CHK;
                S_FL_CHK: begin
                    if (!rd_is_idx_s) begin
                        ram_addr <= rd_addr_s;
                        state_r  <= S_FL_ISS2;
                    end else if (flat_last_s) begin
                        state_r    <= S_RESOLVE;
                        phase      <= 3'd4;
                        find_ready <= 1'b1;
                    end else begin
                        idx_r    <= idx_r + ADDR_ONE;
                        ram_addr <= idx_r + ADDR_ONE;
                        state_r  <= S_FL_ISS;
                    end
                end
                S_FL_ISS2: state_r <= S_FL_CHK2;
                S_FL_CHK2: begin
                    ram_we    <= 1'b1;
                    ram_addr  <= idx_r;
                    ram_wdata <= ram_rdata;
                    state_r   <= S_FL_WR;
                end
                S_FL_WR: begin
                    ram_we <= 1'b0;
                    if (flat_last_s) begin
                        state_r    <= S_RESOLVE;
                        phase      <= 3'd4;
                        find_ready <= 1'b1;
                    end else begin
                        idx_r    <= idx_r + ADDR_ONE;
                        ram_addr <= idx_r + ADDR_ONE;
                        state_r  <= S_FL_ISS;
                    end
                end
                S_RESOLVE: begin
                    v1_r   <= find_valid;
                    oor1_r <= f_oor_s;
                    if (find_valid) begin
                        ram_addr <= ADDR_WIDTH'(find_label);
                        err      <= err | f_oor_s;
                    end
                    v2_r       <= v1_r;
                    oor2_r     <= oor1_r;
                    root_valid <= v2_r;
                    if (v2_r) begin
                        root_label <= oor2_r ? LABEL_ZERO : ram_rdata;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    phase   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccl_table_ctrl.sv
// Randomized self-checking bench for ccl_table_ctrl with a behavioural RAM and a
// union-find reference model.
module tb_ccl_table_ctrl;
    localparam int LW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, frame_start, union_valid, union_ready, scan_done;
    logic find_valid, find_ready, root_valid, ram_we, err;
    logic [LW-1:0] union_a, union_b, max_label, find_label, root_label, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [2:0] phase;

    ccl_table_ctrl #(.LABEL_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .union_valid(union_valid), .union_ready(union_ready),
        .union_a(union_a), .union_b(union_b),
        .scan_done(scan_done), .max_label(max_label),
        .find_valid(find_valid), .find_ready(find_ready), .find_label(find_label),
        .root_valid(root_valid), .root_label(root_label),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .phase(phase), .err(err)
    );

    logic [LW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int wr_addr_q[$];
    int wr_data_q[$];
    always @(posedge clk) begin
        if (ram_we === 1'b1) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(int'(ram_wdata));
        end
    end

    int tbl[DEPTH];
    bit exp_err;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int root_of(int x);
        while (tbl[x] != x) x = tbl[x];
        return x;
    endfunction

    function automatic int depth_of(int x);
        int d = 0;
        while (tbl[x] != x) begin
            x = tbl[x];
            d++;
        end
        return d;
    endfunction

    function automatic int flat_cost(int m);
        int c = 0;
        for (int i = 1; i <= m; i++) c += (tbl[i] == i) ? 2 : 5;
        return c;
    endfunction

    task automatic do_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (ram_we !== 1'b1 || ram_addr !== i[AW-1:0] || ram_wdata !== i[LW-1:0] || phase !== 3'd1) begin
                n_bad++;
                $display("FAIL clear_write[%0d]: we=%0b addr=%0d data=%0d phase=%0d, expected we=1 addr=%0d data=%0d phase=1",
                         i, ram_we, ram_addr, ram_wdata, phase, i, i);
            end
            step();
        end
        n_cmp++;
        if (phase !== 3'd2 || union_ready !== 1'b1 || ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_exit: phase=%0d ready=%0b we=%0b, expected phase=2 ready=1 we=0", phase, union_ready, ram_we);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_err: err=%0b, expected 0", err);
        end
        for (int i = 0; i < DEPTH; i++) tbl[i] = i;
        exp_err = 1'b0;
    endtask

    task automatic do_union(input int a, input int b);
        int exp_low, exp_wa, exp_wd, ra, rb, low, guard;
        bit exp_wr;
        exp_wa = 0;
        exp_wd = 0;
        exp_wr = 1'b0;
        if (a == 0 || b == 0 || a == b || a >= DEPTH || b >= DEPTH) begin
            exp_low = 1;
            if (a >= DEPTH || b >= DEPTH) exp_err = 1'b1;
        end else begin
            ra = root_of(a);
            rb = root_of(b);
            exp_low = 2 * (depth_of(a) + 1) + 2 * (depth_of(b) + 1) + 1;
            if (ra != rb) begin
                exp_wr = 1'b1;
                exp_wa = (ra > rb) ? ra : rb;
                exp_wd = (ra > rb) ? rb : ra;
                tbl[exp_wa] = exp_wd;
            end
        end
        guard = 0;
        while (union_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL union_wait_ready(%0d,%0d): ready=%0b, expected 1 within 50 cycles", a, b, union_ready);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        union_valid = 1'b1;
        union_a = LW'(a);
        union_b = LW'(b);
        step();
        union_valid = 1'b0;
        low = 0;
        while (union_ready !== 1'b1 && low < 200) begin
            low++;
            step();
        end
        n_cmp++;
        if (low !== exp_low) begin
            n_bad++;
            $display("FAIL union_ready_low(%0d,%0d): got %0d cycles, expected %0d", a, b, low, exp_low);
        end
        n_cmp++;
        if (wr_addr_q.size() !== int'(exp_wr)) begin
            n_bad++;
            $display("FAIL union_write_count(%0d,%0d): got %0d, expected %0d", a, b, wr_addr_q.size(), int'(exp_wr));
        end else if (exp_wr) begin
            n_cmp++;
            if (wr_addr_q[0] !== exp_wa || wr_data_q[0] !== exp_wd) begin
                n_bad++;
                $display("FAIL union_write(%0d,%0d): got table[%0d]=%0d, expected table[%0d]=%0d",
                         a, b, wr_addr_q[0], wr_data_q[0], exp_wa, exp_wd);
            end
        end
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++;
            $display("FAIL union_err(%0d,%0d): err=%0b, expected %0b", a, b, err, exp_err);
        end
    endtask

    task automatic wait_flatten(input int exp_cyc);
        int g, cyc;
        g = 0;
        while (phase !== 3'd3 && phase !== 3'd4 && g < 20) begin
            step();
            g++;
        end
        cyc = 0;
        while (phase === 3'd3 && cyc < 5000) begin
            cyc++;
            step();
        end
        n_cmp++;
        if (cyc !== exp_cyc) begin
            n_bad++;
            $display("FAIL flatten_cycles: got %0d, expected %0d", cyc, exp_cyc);
        end
        n_cmp++;
        if (phase !== 3'd4 || find_ready !== 1'b1 || union_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL resolve_entry: phase=%0d find_ready=%0b union_ready=%0b, expected 4/1/0", phase, find_ready, union_ready);
        end
        for (int i = 0; i < 128; i++) begin
            n_cmp++;
            if (mem[i] !== LW'(tbl[i])) begin
                n_bad++;
                $display("FAIL table_after_flatten[%0d]: got %0d, expected %0d", i, mem[i], tbl[i]);
            end
        end
    endtask

    task automatic do_flatten(input int m);
        int cost;
        cost = flat_cost(m);
        scan_done = 1'b1;
        max_label = LW'(m);
        step();
        scan_done = 1'b0;
        for (int i = 1; i <= m; i++) tbl[i] = root_of(i);
        wait_flatten(cost);
    endtask

    task automatic do_finds(input int labs[$]);
        int n, l;
        n = labs.size();
        for (int j = 0; j <= n + 3; j++) begin
            if (j >= 3 && j - 3 < n) begin
                l = labs[j-3];
                n_cmp++;
                if (root_valid !== 1'b1 || root_label !== LW'((l >= DEPTH) ? 0 : tbl[l])) begin
                    n_bad++;
                    $display("FAIL find(%0d): valid=%0b root=%0d, expected valid=1 root=%0d",
                             l, root_valid, root_label, (l >= DEPTH) ? 0 : tbl[l]);
                end
            end else begin
                n_cmp++;
                if (root_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL find_idle_valid[%0d]: valid=%0b, expected 0", j, root_valid);
                end
            end
            if (j >= 1 && j - 1 < n && labs[j-1] < DEPTH) begin
                l = labs[j-1];
                n_cmp++;
                if (ram_addr !== l[AW-1:0]) begin
                    n_bad++;
                    $display("FAIL find_addr(%0d): ram_addr=%0d, expected %0d", l, ram_addr, l);
                end
            end
            if (j < n) begin
                find_valid = 1'b1;
                find_label = LW'(labs[j]);
                if (labs[j] >= DEPTH) exp_err = 1'b1;
            end else begin
                find_valid = 1'b0;
            end
            step();
        end
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++;
            $display("FAIL find_err: err=%0b, expected %0b", err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b0; union_valid = 1'b0; scan_done = 1'b0; find_valid = 1'b0;
        union_a = '0; union_b = '0; max_label = '0; find_label = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (phase !== 3'd0 || union_ready !== 1'b0 || find_ready !== 1'b0 || root_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: phase=%0d ur=%0b fr=%0b rv=%0b, expected all 0", phase, union_ready, find_ready, root_valid);
        end
        n_cmp++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 || root_label !== '0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data: we=%0b addr=%0d wdata=%0d root=%0d err=%0b, expected all 0",
                     ram_we, ram_addr, ram_wdata, root_label, err);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        union_valid = 1'b1; union_a = 16'd3; union_b = 16'd1;
        repeat (4) step();
        union_valid = 1'b0;
        n_cmp++;
        if (union_ready !== 1'b0 || wr_addr_q.size() !== 0) begin
            n_bad++;
            $display("FAIL idle_ignores_union: ready=%0b writes=%0d, expected 0/0", union_ready, wr_addr_q.size());
        end
    endtask

    task automatic test_union_fresh();
        do_frame();
        do_union(3, 1);
    endtask

    task automatic test_special();
        do_union(0, 5);
        do_union(7, 7);
        do_union(2000, 1);
    endtask

    task automatic test_chain();
        do_frame();
        do_union(2, 1);
        do_union(3, 2);
        do_union(4, 3);
        do_union(4, 2);
        do_flatten(4);
        do_finds('{1, 2, 3, 4});
        do_finds('{1500, 2});
    endtask

    task automatic test_max_zero();
        do_frame();
        do_union(5, 3);
        do_flatten(0);
        do_finds('{5, 3});
    endtask

    task automatic build_deep();
        do_union(5, 4);
        do_union(4, 3);
        do_union(3, 2);
        do_union(2, 1);
    endtask

    task automatic test_abort();
        do_frame();
        build_deep();
        wr_addr_q.delete();
        wr_data_q.delete();
        union_valid = 1'b1; union_a = 16'd5; union_b = 16'd9;
        step();
        union_valid = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (union_ready !== 1'b0 || phase !== 3'd2 || wr_addr_q.size() !== 0) begin
            n_bad++;
            $display("FAIL abort_midwalk: ready=%0b phase=%0d writes=%0d, expected 0/2/0", union_ready, phase, wr_addr_q.size());
        end
        do_frame();
    endtask

    task automatic test_scan_mid();
        int g, cost;
        bit ready_seen;
        build_deep();
        wr_addr_q.delete();
        wr_data_q.delete();
        union_valid = 1'b1; union_a = 16'd5; union_b = 16'd9;
        step();
        union_valid = 1'b0;
        tbl[9] = 1;
        step();
        scan_done = 1'b1; max_label = 16'd9;
        step();
        scan_done = 1'b0;
        ready_seen = 1'b0;
        g = 0;
        while (phase !== 3'd3 && g < 60) begin
            if (union_ready === 1'b1) ready_seen = 1'b1;
            step();
            g++;
        end
        n_cmp++;
        if (phase !== 3'd3 || ready_seen) begin
            n_bad++;
            $display("FAIL scan_mid_entry: phase=%0d ready_seen=%0b, expected 3/0", phase, ready_seen);
        end
        n_cmp++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 9 || wr_data_q[0] !== 1) begin
            n_bad++;
            $display("FAIL scan_mid_link: writes=%0d first=table[%0d]=%0d, expected 1 write table[9]=1",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, (wr_data_q.size() > 0) ? wr_data_q[0] : -1);
        end
        cost = flat_cost(9);
        for (int i = 1; i <= 9; i++) tbl[i] = root_of(i);
        wait_flatten(cost);
        do_finds('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    endtask

    task automatic test_random();
        int a, b, m;
        int labs[$];
        do_frame();
        for (int k = 0; k < 40; k++) begin
            a = $urandom_range(0, 48);
            b = $urandom_range(0, 48);
            if ($urandom_range(0, 15) == 0) a = 1024 + $urandom_range(0, 500);
            do_union(a, b);
        end
        m = $urandom_range(16, 48);
        do_flatten(m);
        for (int k = 0; k < 24; k++) labs.push_back($urandom_range(0, 60));
        labs.push_back(1100);
        labs.push_back($urandom_range(1, 48));
        do_finds(labs);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_union_fresh();
        test_special();
        test_chain();
        test_max_zero();
        test_abort();
        test_scan_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
